branch_resolve_unit: RTL and testbench

Resolution-side counterpart to the fetch-stage direction predictor. It records each decoded branch's prediction and predicted target in an in-order queue, and compares the oldest record against the actual outcome when the branch resolves in MEM. On a mismatch it raises a flush, supplies the redirect PC and holds recovery until fetch returns. For every resolved branch it emits a registered training update toward the predictor tables.

---
 rtl/branch_resolve_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order queue of fetch predictions checked against MEM outcomes,
// with flush/redirect recovery and predictor training. Optional counters: BRU_PERFCNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             id_isbranch,
    input  logic             id_advance,
    input  logic             id_pred_taken,
    input  logic [31:0]      id_pred_target,
    input  logic             mem_resolve,
    input  logic             mem_taken,
    input  logic [31:0]      mem_pc,
    input  logic [31:0]      mem_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    output logic             q_full,
    output logic             q_err
`ifdef BRU_PERFCNT_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      mispred_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_RECOVER} state_t;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    state_t                 state_q, state_d;
    entry_t [DEPTH-1:0]     entries_q, entries_d;
    logic   [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic   [CNT_W-1:0]     count_q, count_d;
    logic                   q_full_q, q_full_d, q_err_q, q_err_d;
    logic                   upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic   [IDX_W-1:0]     upd_idx_q, upd_idx_d;

    logic   q_empty, q_at_depth, pop_fire, do_pop, push_req, do_push;
    logic   mispredict, flush_eff;
    entry_t head;

    // An empty-queue pop sees an all-zero record, i.e. predicted not-taken.
    always_comb begin
        q_empty    = (count_q == '0);
        q_at_depth = (count_q == CNT_W'(DEPTH));
        pop_fire   = mem_resolve & ihit & (state_q == ST_RUN);
        head       = q_empty ? '0 : entries_q[rd_ptr_q];
        mispredict = pop_fire & ((head.pred_taken != mem_taken) |
                                 (mem_taken & (head.pred_target != mem_target)));
        flush_eff  = mispredict | (state_q == ST_RECOVER);
        push_req   = id_isbranch & id_advance & ihit & ~flush_eff;
        do_pop     = pop_fire & ~q_empty;
        do_push    = push_req & (~q_at_depth | do_pop);
    end

    always_comb begin
        state_d     = state_q;
        entries_d   = entries_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        q_err_d     = q_err_q;
        upd_valid_d = pop_fire;
        upd_idx_d   = upd_idx_q;
        upd_taken_d = upd_taken_q;

        if (do_push) begin
            entries_d[wr_ptr_q] = '{pred_taken: id_pred_taken, pred_target: id_pred_target};
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end

        if ((push_req && q_at_depth && !do_pop) || (pop_fire && q_empty)) begin
            q_err_d = 1'b1;
        end

        if (pop_fire) begin
            upd_idx_d   = mem_pc[IDX_W+1:2];
            upd_taken_d = mem_taken;
        end

        // A mispredict discards every younger record along with the wrong-path fetch.
        unique case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d  = ST_RECOVER;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            ST_RECOVER: begin
                if (ihit) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        q_full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_RUN;
            entries_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            q_full_q    <= 1'b0;
            q_err_q     <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            entries_q   <= entries_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            q_full_q    <= q_full_d;
            q_err_q     <= q_err_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
        end
    end

    assign flush          = flush_eff;
    assign redirect_valid = mispredict;
    assign redirect_pc    = mispredict ? (mem_taken ? mem_target : mem_pc + 32'd4) : '0;
    assign upd_valid      = upd_valid_q;
    assign upd_idx        = upd_idx_q;
    assign upd_taken      = upd_taken_q;
    assign q_full         = q_full_q;
    assign q_err          = q_err_q;

`ifdef BRU_PERFCNT_EN
    logic [31:0] br_count_q, br_count_d, mispred_count_q, mispred_count_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (pop_fire && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit; counter checks need BRU_PERFCNT_EN.
module tb_branch_resolve_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        CLK, nRST, ihit, id_isbranch, id_advance, id_pred_taken;
    logic [31:0] id_pred_target, mem_pc, mem_target, redirect_pc;
    logic        mem_resolve, mem_taken, flush, redirect_valid, upd_valid, upd_taken;
    logic [3:0]  upd_idx;
    logic        q_full, q_err;
`ifdef BRU_PERFCNT_EN
    logic [31:0] br_count, mispred_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ih, isb, pt;
        logic [31:0] ptgt;
        logic        res, tk;
        logic [31:0] pc, tgt;
        logic        e_flush, e_rv;
        logic [31:0] e_rpc;
        logic        e_uv;
        logic [3:0]  e_idx;
        logic        e_ut, e_full, e_err;
    } vec_t;

    vec_t vq[$];

    branch_resolve_unit #(.DEPTH(4), .IDX_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit),
        .id_isbranch(id_isbranch), .id_advance(id_advance),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .mem_resolve(mem_resolve), .mem_taken(mem_taken),
        .mem_pc(mem_pc), .mem_target(mem_target),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .q_full(q_full), .q_err(q_err)
`ifdef BRU_PERFCNT_EN
        , .br_count(br_count), .mispred_count(mispred_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk_vec(input logic ih, input logic isb, input logic pt,
                                    input logic [31:0] ptgt, input logic res, input logic tk,
                                    input logic [31:0] pc, input logic [31:0] tgt,
                                    input logic ef, input logic erv, input logic [31:0] erpc,
                                    input logic euv, input logic [3:0] eidx, input logic eut,
                                    input logic efull, input logic eerr);
        vec_t v;
        v.ih = ih; v.isb = isb; v.pt = pt; v.ptgt = ptgt;
        v.res = res; v.tk = tk; v.pc = pc; v.tgt = tgt;
        v.e_flush = ef; v.e_rv = erv; v.e_rpc = erpc;
        v.e_uv = euv; v.e_idx = eidx; v.e_ut = eut; v.e_full = efull; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        ihit           = v.ih;
        id_isbranch    = v.isb;
        id_advance     = v.isb;
        id_pred_taken  = v.pt;
        id_pred_target = v.ptgt;
        mem_resolve    = v.res;
        mem_taken      = v.tk;
        mem_pc         = v.pc;
        mem_target     = v.tgt;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        #1;
        chk($sformatf("v%0d flush", idx), {31'b0, flush}, {31'b0, v.e_flush});
        chk($sformatf("v%0d redirect_valid", idx), {31'b0, redirect_valid}, {31'b0, v.e_rv});
        chk($sformatf("v%0d redirect_pc", idx), redirect_pc, v.e_rpc);
        chk($sformatf("v%0d upd_valid", idx), {31'b0, upd_valid}, {31'b0, v.e_uv});
        if (v.e_uv) begin
            chk($sformatf("v%0d upd_idx", idx), {28'b0, upd_idx}, {28'b0, v.e_idx});
            chk($sformatf("v%0d upd_taken", idx), {31'b0, upd_taken}, {31'b0, v.e_ut});
        end
        chk($sformatf("v%0d q_full", idx), {31'b0, q_full}, {31'b0, v.e_full});
        chk($sformatf("v%0d q_err", idx), {31'b0, q_err}, {31'b0, v.e_err});
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, " flush"}, {31'b0, flush}, 32'h0);
        chk({tag, " redirect_valid"}, {31'b0, redirect_valid}, 32'h0);
        chk({tag, " redirect_pc"}, redirect_pc, 32'h0);
        chk({tag, " upd_valid"}, {31'b0, upd_valid}, 32'h0);
        chk({tag, " upd_idx"}, {28'b0, upd_idx}, 32'h0);
        chk({tag, " upd_taken"}, {31'b0, upd_taken}, 32'h0);
        chk({tag, " q_full"}, {31'b0, q_full}, 32'h0);
        chk({tag, " q_err"}, {31'b0, q_err}, 32'h0);
`ifdef BRU_PERFCNT_EN
        chk({tag, " br_count"}, br_count, 32'h0);
        chk({tag, " mispred_count"}, mispred_count, 32'h0);
`endif
    endtask

    initial begin
        vec_t v;

        // In-order resolves that all match their predictions
        vq.push_back(mk_vec(H,H,H,32'h40,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h80,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,H,32'h10,32'h40,  L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h14,32'h99,  L,L,32'h0, H,4'h4,H, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,H,32'h18,32'h80,  L,L,32'h0, H,4'h5,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, H,4'h6,H, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        // Not-taken predicted, taken actual, with a second record queued behind it
        vq.push_back(mk_vec(H,H,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h90,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h200, H,H,32'h20,32'h100, H,H,32'h100, L,4'h0,L, L,L));
        vq.push_back(mk_vec(L,L,L,32'h0,   L,L,32'h0,32'h0,    H,L,32'h0, H,4'h8,H, L,L));
        vq.push_back(mk_vec(L,L,L,32'h0,   L,L,32'h0,32'h0,    H,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(L,L,L,32'h0,   L,L,32'h0,32'h0,    H,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h300, H,H,32'h44,32'h999, H,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h60,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,H,32'h50,32'h60,  L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, H,4'h4,H, L,L));
        // Taken predicted, not-taken actual; then taken with a wrong target
        vq.push_back(mk_vec(H,H,H,32'h60,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h3C,32'h60,  H,H,32'h40, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    H,L,32'h0, H,4'hF,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,H,32'h60,  L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,H,32'h70,32'h64,  H,H,32'h64, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    H,L,32'h0, H,4'hC,H, L,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,L));
        // Fill, push+pop while full, dropped push, then drain
        for (int i = 0; i < 4; i++)
            vq.push_back(mk_vec(H,H,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L));
        vq.push_back(mk_vec(H,H,L,32'h0,   H,L,32'h80,32'h0,   L,L,32'h0, L,4'h0,L, H,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, H,4'h0,L, H,L));
        vq.push_back(mk_vec(H,H,H,32'h500, L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, H,L));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, H,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h100,32'h0,  L,L,32'h0, L,4'h0,L, H,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h104,32'h0,  L,L,32'h0, H,4'h0,L, L,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h108,32'h0,  L,L,32'h0, H,4'h1,L, L,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   H,L,32'h10C,32'h0,  L,L,32'h0, H,4'h2,L, L,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, H,4'h3,L, L,H));
        vq.push_back(mk_vec(H,L,L,32'h0,   L,L,32'h0,32'h0,    L,L,32'h0, L,4'h0,L, L,H));

        nRST = 1'b0;
        applyStimulus(mk_vec(L,L,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L));
        repeat (2) @(posedge CLK);
        #1;
        checkResetState("reset");
        nRST = 1'b1;

        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            checkOutput(vq[i], i);
        end

        // Reset pulse clears the sticky error and all registered state
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        checkResetState("reset2");
        @(negedge CLK);
        nRST = 1'b1;

`ifdef BRU_PERFCNT_EN
        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = (i == 0 || i == 3 || i == 6);
            applyStimulus(mk_vec(H,H,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L));
            applyStimulus(mk_vec(H,L,L,32'h0, H,tk,32'h200 + 32'(i*4),32'h100,
                                 L,L,32'h0, L,4'h0,L, L,L));
            #1;
            chk($sformatf("perf%0d flush", i), {31'b0, flush}, {31'b0, tk});
            if (tk)
                applyStimulus(mk_vec(H,L,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L));
        end
        applyStimulus(mk_vec(H,L,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L));
        #1;
        chk("br_count", br_count, 32'd10);
        chk("mispred_count", mispred_count, 32'd3);
`endif

        // Resolve on an empty queue: treated as not-taken, then reset mid-recovery
        v = mk_vec(H,L,L,32'h0, H,H,32'h200,32'h300, H,H,32'h300, L,4'h0,L, L,L);
        applyStimulus(v);
        checkOutput(v, 100);
        v = mk_vec(L,L,L,32'h0, L,L,32'h0,32'h0, H,L,32'h0, H,4'h0,H, L,H);
        applyStimulus(v);
        checkOutput(v, 101);
        #1;
        nRST = 1'b0;
        #1;
        checkResetState("reset_recover");
        @(negedge CLK);
        nRST = 1'b1;
        v = mk_vec(H,L,L,32'h0, L,L,32'h0,32'h0, L,L,32'h0, L,4'h0,L, L,L);
        applyStimulus(v);
        checkOutput(v, 102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
